bus_responder: RTL

// - Target side of the CPU external bus. Answers CPU read/write cycles to an 8-byte register window.
// - Drives ready low for programmable wait states on reads. Writes are never stalled, since the CPU ignores ready on writes.
// - Contains a 16-bit reload timer that drives the CPU interruptRequest and nonMaskableInterrupt inputs.
// - Sits beside the CPU top in the system/FPGA wrapper; the wrapper muxes dataBusInput using hit.

---
 rtl/bus_responder_pkg.sv | 22 ++
 rtl/responder_timer.sv | 62 ++++++
 rtl/bus_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_pkg.sv
// Shared definitions for the CPU bus responder: register offsets inside the
// 8-byte window, CTRL bit positions and the read-stall FSM state type.
package bus_responder_pkg;

  localparam logic [2:0] REG_SCRATCH0  = 3'd0;
  localparam logic [2:0] REG_SCRATCH1  = 3'd1;
  localparam logic [2:0] REG_RELOAD_LO = 3'd2;
  localparam logic [2:0] REG_RELOAD_HI = 3'd3;
  localparam logic [2:0] REG_CTRL      = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;
  localparam logic [2:0] REG_COUNT_LO  = 3'd6;
  localparam logic [2:0] REG_COUNT_HI  = 3'd7;

  localparam int CTRL_TEN    = 0;
  localparam int CTRL_IRQEN  = 1;
  localparam int CTRL_NMIEN  = 2;
  localparam int CTRL_WS_LSB = 4;
  localparam int CTRL_WS_MSB = 6;

  typedef enum logic {RSP_IDLE, RSP_WAIT} rsp_state_t;

endpackage

// File: rtl/responder_timer.sv
// 16-bit reload down-counter with sticky expired flag and a one-cycle NMI
// pulse that follows each expiry when NMI is enabled.
module responder_timer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ten,
  input  logic        nmien,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic [15:0] reload_value,
  input  logic        clear,
  output logic [15:0] count,
  output logic        expired,
  output logic        nmi
);

  logic [15:0] count_q, count_d;
  logic        expired_q, expired_d;
  logic        nmi_q, nmi_d;
  logic        expire;

  // Next-state: an explicit load beats counting, and an expiry beats a clear.
  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    expire    = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (ten) begin
      if (count_q == 16'd0) begin
        count_d = reload_value;
        expire  = 1'b1;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
    if (expire) begin
      expired_d = 1'b1;
    end else if (clear) begin
      expired_d = 1'b0;
    end
    nmi_d = expire & nmien;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q   <= 16'd0;
      expired_q <= 1'b0;
      nmi_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
      nmi_q     <= nmi_d;
    end
  end

  assign count   = count_q;
  assign expired = expired_q;
  assign nmi     = nmi_q;

endmodule

// File: rtl/bus_responder.sv
// CPU bus target: address decode, register window, read wait-state FSM and
// read data mux. The timer lives in responder_timer.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hD000,
  parameter logic [2:0]  DEFAULT_WAIT = 3'd2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] AddressBusHigh,
  input  logic [7:0] AddressBusLow,
  input  logic       readNotWrite,
  input  logic [7:0] cpuWriteData,
  output logic [7:0] dataBusInput,
  output logic       ready,
  output logic       hit,
  output logic       interruptRequest,
  output logic       nonMaskableInterrupt
);

  logic [2:0]  offset;
  logic        rd_req, wr_en;
  logic [7:0]  scratch0_q, scratch0_d, scratch1_q, scratch1_d;
  logic [7:0]  reload_lo_q, reload_lo_d, reload_hi_q, reload_hi_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        ten_q, ten_d, irqen_q, irqen_d, nmien_q, nmien_d;
  logic [2:0]  ws_q, ws_d;
  logic [2:0]  cnt_q, cnt_d;
  rsp_state_t  state_q, state_d;
  logic        ready_fsm, rd_done;
  logic        timer_load, status_clear;
  logic [15:0] count;
  logic        expired;
  logic [7:0]  rdata;

  assign offset = AddressBusLow[2:0];
  assign hit    = ({AddressBusHigh, AddressBusLow[7:3]} == BASE_ADDR[15:3]);
  assign rd_req = hit & readNotWrite;
  assign wr_en  = hit & ~readNotWrite;

  // Read stall FSM; ready is Mealy because the stall must show in the first cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_fsm = 1'b1;
    rd_done   = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (rd_req) begin
          if (ws_q != 3'd0) begin
            ready_fsm = 1'b0;
            cnt_d     = ws_q - 3'd1;
            state_d   = RSP_WAIT;
          end else begin
            rd_done = 1'b1;
          end
        end
      end
      RSP_WAIT: begin
        if (!rd_req) begin
          state_d = RSP_IDLE;
        end else if (cnt_q != 3'd0) begin
          ready_fsm = 1'b0;
          cnt_d     = cnt_q - 3'd1;
        end else begin
          state_d = RSP_IDLE;
          rd_done = 1'b1;
        end
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RSP_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While reset is held the CPU must never see a stall.
  assign ready = ready_fsm | ~nrst;

  // Register file writes plus the COUNT_LO shadow latch on a completed read.
  always_comb begin
    scratch0_d   = scratch0_q;
    scratch1_d   = scratch1_q;
    reload_lo_d  = reload_lo_q;
    reload_hi_d  = reload_hi_q;
    ten_d        = ten_q;
    irqen_d      = irqen_q;
    nmien_d      = nmien_q;
    ws_d         = ws_q;
    shadow_d     = shadow_q;
    timer_load   = 1'b0;
    status_clear = 1'b0;
    if (wr_en) begin
      case (offset)
        REG_SCRATCH0:  scratch0_d = cpuWriteData;
        REG_SCRATCH1:  scratch1_d = cpuWriteData;
        REG_RELOAD_LO: reload_lo_d = cpuWriteData;
        REG_RELOAD_HI: begin
          reload_hi_d = cpuWriteData;
          timer_load  = 1'b1;
        end
        REG_CTRL: begin
          ten_d   = cpuWriteData[CTRL_TEN];
          irqen_d = cpuWriteData[CTRL_IRQEN];
          nmien_d = cpuWriteData[CTRL_NMIEN];
          ws_d    = cpuWriteData[CTRL_WS_MSB:CTRL_WS_LSB];
        end
        REG_STATUS:    status_clear = cpuWriteData[0];
        default: ;
      endcase
    end
    if (rd_done && (offset == REG_COUNT_LO)) begin
      shadow_d = count[15:8];
    end
  end

  // Register file flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      scratch0_q  <= 8'h00;
      scratch1_q  <= 8'h00;
      reload_lo_q <= 8'h00;
      reload_hi_q <= 8'h00;
      ten_q       <= 1'b0;
      irqen_q     <= 1'b0;
      nmien_q     <= 1'b0;
      ws_q        <= DEFAULT_WAIT;
      shadow_q    <= 8'h00;
    end else begin
      scratch0_q  <= scratch0_d;
      scratch1_q  <= scratch1_d;
      reload_lo_q <= reload_lo_d;
      reload_hi_q <= reload_hi_d;
      ten_q       <= ten_d;
      irqen_q     <= irqen_d;
      nmien_q     <= nmien_d;
      ws_q        <= ws_d;
      shadow_q    <= shadow_d;
    end
  end

  responder_timer u_timer (
    .clk          (clk),
    .nrst         (nrst),
    .ten          (ten_q),
    .nmien        (nmien_q),
    .load         (timer_load),
    .load_value   ({cpuWriteData, reload_lo_q}),
    .reload_value ({reload_hi_q, reload_lo_q}),
    .clear        (status_clear),
    .count        (count),
    .expired      (expired),
    .nmi          (nonMaskableInterrupt)
  );

  // Read data mux; unused CTRL/STATUS bits read as zero.
  always_comb begin
    rdata = 8'h00;
    case (offset)
      REG_SCRATCH0:  rdata = scratch0_q;
      REG_SCRATCH1:  rdata = scratch1_q;
      REG_RELOAD_LO: rdata = reload_lo_q;
      REG_RELOAD_HI: rdata = reload_hi_q;
      REG_CTRL:      rdata = {1'b0, ws_q, 1'b0, nmien_q, irqen_q, ten_q};
      REG_STATUS:    rdata = {7'd0, expired};
      REG_COUNT_LO:  rdata = count[7:0];
      REG_COUNT_HI:  rdata = shadow_q;
      default:       rdata = 8'h00;
    endcase
  end

  assign dataBusInput     = rd_req ? rdata : 8'h00;
  assign interruptRequest = expired & irqen_q;

endmodule
